// File: rtl/x_stack_mw.sv
// rtl/x_stack_mw.sv - attestation access monitor with registered MCU kill/reset
module x_stack_mw #(
    parameter logic [15:0]        SMEM_BASE     = 16'hA000,
    parameter logic [15:0]        SMEM_SIZE     = 16'h4000,
    parameter logic [15:0]        SDATA_BASE    = 16'h0400,
    parameter logic [15:0]        SDATA_SIZE    = 16'h0C00,
    parameter int                 NW            = 2,
    parameter logic [NW*16-1:0]   WIN_BASE      = {16'h0270, 16'h8000},
    parameter logic [NW*16-1:0]   WIN_SIZE      = {16'h0020, 16'h0020},
    parameter logic [NW-1:0]      WIN_LOCK      = 2'b10,
    parameter logic [15:0]        RESET_HANDLER = 16'hFFFE,
    parameter int                 HOLD_CYCLES   = 4,
    parameter int                 CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      pc,
    input  logic [15:0]      data_addr,
    input  logic             r_en,
    input  logic             w_en,
    output logic             reset,
    output logic [2:0]       viol_cause,
    output logic [CNT_W-1:0] viol_count
);

    // Region bounds widened to 17 bits so a region ending at 16'hFFFF cannot wrap.
    localparam logic [16:0] SROM_LO  = {1'b0, SMEM_BASE};
    localparam logic [16:0] SROM_HI  = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd2;
    localparam logic [16:0] SDATA_LO = {1'b0, SDATA_BASE};
    localparam logic [16:0] SDATA_HI = {1'b0, SDATA_BASE} + {1'b0, SDATA_SIZE} - 17'd1;

    localparam int             HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD    = 2'd1,
        WAIT    = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic           capture;

    logic [16:0]    pc_x, addr_x;
    logic           in_srom, in_sdata;
    logic [NW-1:0]  in_win;
    logic           v0, v1, v2, any_v;

    assign pc_x     = {1'b0, pc};
    assign addr_x   = {1'b0, data_addr};
    assign in_srom  = (pc_x >= SROM_LO) && (pc_x <= SROM_HI);
    assign in_sdata = (addr_x >= SDATA_LO) && (addr_x <= SDATA_HI);

    for (genvar i = 0; i < NW; i++) begin : g_win
        localparam logic [16:0] LO = {1'b0, WIN_BASE[16*i +: 16]};
        localparam logic [16:0] HI = LO + {1'b0, WIN_SIZE[16*i +: 16]} - 17'd1;
        assign in_win[i] = (addr_x >= LO) && (addr_x <= HI);
    end

    // Untrusted secure-data access, trusted stray write, untrusted locked-window write.
    assign v0    = !in_srom && in_sdata && (r_en || w_en);
    assign v1    = in_srom && w_en && !in_sdata && !(|in_win);
    assign v2    = !in_srom && w_en && |(in_win & WIN_LOCK);
    assign any_v = v0 | v1 | v2;

    // Next-state logic: kill on violation, hold for the minimum time, release at the handler.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        capture = 1'b0;
        case (state_q)
            RUN: begin
                if (any_v) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                    capture = 1'b1;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = WAIT;
                end else begin
                    hold_d = hold_q - HCW'(1);
                end
            end
            WAIT: begin
                if ((pc == RESET_HANDLER) && !any_v) begin
                    state_d = RUN;
                end
            end
            default: begin
                // A corrupted state is treated as a kill, without touching the debug record.
                state_d = HOLD;
                hold_d  = HOLD_LOAD;
            end
        endcase
    end

    // State, hold counter, registered reset and the debug record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            hold_q     <= '0;
            reset      <= 1'b0;
            viol_cause <= 3'b000;
            viol_count <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            reset   <= (state_d != RUN);
            if (capture) begin
                viol_cause <= {v2, v1, v0};
                if (viol_count != {CNT_W{1'b1}}) begin
                    viol_count <= viol_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/x_stack_mw.md
# x_stack_mw

Parametrised hardware access monitor for the attestation core. It checks every CPU data access against a secure-ROM code region, a secure-data region and `NW` configurable side windows. On any violation it drives a registered `reset` to the MCU. `reset` is held for at least `HOLD_CYCLES` cycles and releases only once the CPU sits at the reset handler with no violation pending. It also records the cause of the last violation and keeps a saturating violation count for debug and test. It sits between the openMSP430 core bus taps and the system reset combiner.

## Interface
Parameters:
- `SMEM_BASE`, 16'hA000, secure-ROM (trusted code) base.
- `SMEM_SIZE`, 16'h4000, secure-ROM size in bytes.
- `SDATA_BASE`, 16'h0400, secure-data base.
- `SDATA_SIZE`, 16'h0C00, secure-data size in bytes.
- `NW`, 2, number of side windows (1..8).
- `WIN_BASE`, {16'h0270,16'h8000}, NW×16 flat vector; window i is at bits [16i+15:16i].
- `WIN_SIZE`, {16'h0020,16'h0020}, NW×16 flat vector of window sizes.
- `WIN_LOCK`, 2'b10, NW bits; bit i=1 means untrusted writes to window i are forbidden.
- `RESET_HANDLER`, 16'hFFFE, pc value that permits release.
- `HOLD_CYCLES`, 4, minimum cycles in the hold state (at least 1).
- `CNT_W`, 8, violation counter width.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc` in 16: current program counter.
- `data_addr` in 16: data bus address.
- `r_en` in 1: data read strobe.
- `w_en` in 1: data write strobe.
- `reset` out 1: registered kill/reset request to the MCU.
- `viol_cause` out 3: cause bits captured at the last RUN→HOLD transition.
- `viol_count` out CNT_W: saturating count of RUN→HOLD transitions.

## Operation
- All range compares are done in 17 bits so that BASE+SIZE cannot wrap.
- `in_srom`: SMEM_BASE ≤ pc ≤ SMEM_BASE+SMEM_SIZE−2.
- `in_sdata`: SDATA_BASE ≤ data_addr ≤ SDATA_BASE+SDATA_SIZE−1.
- `in_win[i]`: WIN_BASE[i] ≤ data_addr ≤ WIN_BASE[i]+WIN_SIZE[i]−1.
- Violation v0 (untrusted secure-data access): !in_srom && in_sdata && (r_en || w_en).
- Violation v1 (trusted write outside allowed space): in_srom && w_en && !in_sdata && !(|in_win).
- Violation v2 (untrusted write to locked window): !in_srom && w_en && |(in_win & WIN_LOCK).
- `any_v` = v0|v1|v2. All three terms are combinational; all registers update on posedge `clk`.
- FSM states:
  - RUN=2'd0.
  - HOLD=2'd1.
  - WAIT=2'd2.
  - 2'd3 is illegal and goes to HOLD, i.e. it is treated as a kill.
- RUN:
  - If `any_v`, go to HOLD.
  - Load `hold_cnt` = HOLD_CYCLES−1.
  - Capture `viol_cause` = {v2,v1,v0}.
  - Increment `viol_count`, saturating at all-ones.
- HOLD:
  - If `hold_cnt`==0, go to WAIT; otherwise decrement.
  - Violations are ignored: no cause capture, no count.
- WAIT:
  - If pc==RESET_HANDLER && !any_v, go to RUN.
  - Otherwise stay in WAIT.
- `reset` is registered and equals 1 in the cycle after the FSM enters HOLD or WAIT, i.e. reset_q <= (next_state != RUN).
- `viol_cause` is sticky across the return to RUN and is overwritten only by the next capture.
- Asynchronous `rst_n` low, at any time including mid-HOLD:
  - state=RUN, hold_cnt=0.
  - reset=0, viol_cause=0, viol_count=0.

## Timing
- Violation sampled at edge N → `reset`=1 from N (visible in cycle N+1). Latency is 1 cycle, matching the previous generation's kill.
- Minimum assertion length of `reset` is HOLD_CYCLES+1 cycles: HOLD_CYCLES cycles in HOLD plus at least one WAIT evaluation.
- If pc==RESET_HANDLER is already present during HOLD, release occurs at the first WAIT edge, giving `reset`=1 for exactly HOLD_CYCLES+1 cycles.
- In WAIT, pc==RESET_HANDLER with `any_v`=1 in the same cycle → stay in WAIT. No recount, no cause update.
- Release edge M → `reset`=0 from M. A new violation at edge M+1 re-kills normally.
- Simultaneous v0 and v2 (untrusted write to an address that is both in secure-data and a locked window) → cause=3'b101, count +1.
- `viol_count` at all-ones: further kills leave it unchanged; no wrap.
- Address at BASE+SIZE (one past the end) is outside the region. A region ending at 16'hFFFF is handled correctly with no wrap.

## Test plan
- Untrusted read: pc=16'h4400, data_addr=16'h0500, r_en=1 for one cycle → `reset`=1 next cycle, cause=3'b001, count=1. `reset` stays 1 for ≥5 cycles (HOLD_CYCLES=4) and until pc=16'hFFFE is presented with no violation, then drops 1 cycle later.
- Trusted write to HMAC: pc=16'hA100, w_en=1, data_addr=16'h8010 → no reset. Same pc with data_addr=16'h9000 → cause=3'b010.
- Untrusted write to counter: pc=16'h4400, data_addr=16'h0270 → cause=3'b100. Repeat with data_addr=16'h0290 → no reset. Repeat with HMAC address 16'h8000 → no reset, because that window is unlocked.
- Boundaries:
  - pc=16'hDFFE is trusted; pc=16'hDFFF is untrusted.
  - data_addr=16'h0FFF is in secure-data; data_addr=16'h1000 is not.
- Release gating: in WAIT, drive pc=16'hFFFE together with an sdata read → `reset` stays 1. Drop the read → release next edge. Violations during HOLD do not increment the count.
- Reset and saturation: pulse `rst_n` low mid-HOLD → reset=0, cause=0, count=0 immediately. With CNT_W=2, four kills → count=3.
